// File: rtl/tone_divider_pkg.sv
// ----------------------------------------------------------------------------
// tone_divider_pkg
//   Shared types and constants for the multi-channel tone divider.
//   - ch_state_t   : per-channel run state (IDLE / RUN / STOPPING)
//   - CNT_W        : default half-period counter width
//   - CLK_HZ       : system clock frequency the constants assume
//   - half_of()    : elaboration-time helper, half-period count for a tone
//   - DEFAULT_HALF : reset half-period (440 Hz at CLK_HZ)
// ----------------------------------------------------------------------------
package tone_divider_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } ch_state_t;

    localparam int          CNT_W  = 24;
    localparam int unsigned CLK_HZ = 50_000_000;

    // Constant function only: used to build parameters, never in logic.
    function automatic int unsigned half_of(input int unsigned freq_hz);
        return CLK_HZ / (2 * freq_hz);
    endfunction

    localparam int unsigned DEFAULT_HALF = half_of(440);

endpackage

// File: rtl/tone_div_ch.sv
// ----------------------------------------------------------------------------
// tone_div_ch
//   One square-wave tone channel. Holds an active half-period (p), a pending
//   half-period (q), a counter and the run state. New periods take effect
//   only at a toggle; stopping never truncates a high phase.
//   Ports:
//     clk, rst   : clock, asynchronous active-high reset
//     en         : run enable (level)
//     load       : 1-cycle strobe, capture half
//     half       : half-period in clk cycles
//     tone       : registered square wave
//     rise       : 1-cycle strobe in the cycle tone goes high
//     busy       : state != IDLE
// ----------------------------------------------------------------------------
module tone_div_ch
    import tone_divider_pkg::*;
#(
    parameter int          CNT_W      = tone_divider_pkg::CNT_W,
    parameter int unsigned RESET_HALF = tone_divider_pkg::DEFAULT_HALF
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] half,
    output logic             tone,
    output logic             rise,
    output logic             busy
);

    ch_state_t        state_q, state_d;
    logic [CNT_W-1:0] p_q, p_d;
    logic [CNT_W-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tone_d, rise_d;

    logic             stop_req;
    logic             tc;
    logic [CNT_W-1:0] p_tc;    // period that becomes active at a toggle
    logic [CNT_W-1:0] p_idle;  // period used to qualify a start from IDLE

    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        q_d      = q_q;
        cnt_d    = cnt_q;
        tone_d   = tone;
        rise_d   = 1'b0;

        stop_req = !en || (p_q == '0);
        // Unsigned >= so the counter can never run past P-1.
        tc       = (cnt_q >= p_q - CNT_W'(1));
        // A load on the terminal-count cycle wins over the pending value.
        p_tc     = load ? half : q_q;
        p_idle   = load ? half : p_q;

        if (load)
            q_d = half;

        unique case (state_q)
            IDLE: begin
                if (load)
                    p_d = half;
                if (en && (p_idle != '0)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    tone_d  = 1'b0;
                end
            end
            RUN, STOPPING: begin
                if (stop_req && !tone) begin
                    // Low phase: nothing to finish, stop right away.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (tc) begin
                    cnt_d = '0;
                    p_d   = p_tc;
                    if (tone) begin
                        tone_d  = 1'b0;
                        state_d = stop_req ? IDLE : RUN;
                    end else if (p_tc == '0) begin
                        // Zero period arriving at a rise would leave an
                        // unbounded high phase; cancel the rise instead.
                        state_d = IDLE;
                    end else begin
                        tone_d  = 1'b1;
                        rise_d  = 1'b1;
                        state_d = RUN;
                    end
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    // High phase with stop pending keeps counting to its end;
                    // en coming back simply resumes RUN with no phase change.
                    state_d = stop_req ? STOPPING : RUN;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                tone_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            p_q     <= CNT_W'(RESET_HALF);
            q_q     <= CNT_W'(RESET_HALF);
            cnt_q   <= '0;
            tone    <= 1'b0;
            rise    <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            tone    <= tone_d;
            rise    <= rise_d;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: rtl/tone_divider_multi.sv
// ----------------------------------------------------------------------------
// tone_divider_multi
//   Multi-channel square-wave tone generator for the buzzer path. Each
//   channel divides i_clk by a runtime half-period; channels are independent.
//   Ports:
//     i_clk, i_reset  : clock, asynchronous active-high reset
//     i_en            : per-channel run enable
//     i_load          : per-channel 1-cycle period capture strobe
//     i_half_period   : channel c slice is [c*CNT_W +: CNT_W]
//     o_clk           : per-channel tone square wave
//     o_edge          : per-channel strobe, same cycle o_clk rises
//     o_busy          : per-channel state != IDLE
//     o_mix           : registered OR of busy channels' o_clk
//   Build option: define TONE_DIVIDER_MIX_EN to generate the mixer; without
//   it o_mix is tied low and no mixer logic exists.
// ----------------------------------------------------------------------------
module tone_divider_multi #(
    parameter int          NUM_CH       = 4,
    parameter int          CNT_W        = tone_divider_pkg::CNT_W,
    parameter int unsigned DEFAULT_HALF = tone_divider_pkg::DEFAULT_HALF
)(
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [NUM_CH-1:0]       i_en,
    input  logic [NUM_CH-1:0]       i_load,
    input  logic [NUM_CH*CNT_W-1:0] i_half_period,
    output logic [NUM_CH-1:0]       o_clk,
    output logic [NUM_CH-1:0]       o_edge,
    output logic [NUM_CH-1:0]       o_busy,
    output logic                    o_mix
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        tone_div_ch #(
            .CNT_W      (CNT_W),
            .RESET_HALF (DEFAULT_HALF)
        ) u_ch (
            .clk  (i_clk),
            .rst  (i_reset),
            .en   (i_en[c]),
            .load (i_load[c]),
            .half (i_half_period[c*CNT_W +: CNT_W]),
            .tone (o_clk[c]),
            .rise (o_edge[c]),
            .busy (o_busy[c])
        );
    end

`ifdef TONE_DIVIDER_MIX_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            o_mix <= 1'b0;
        else
            o_mix <= |(o_clk & o_busy);
    end
`else
    assign o_mix = 1'b0;
`endif

endmodule

// File: tb/tb_tone_divider_multi.sv
module tb_tone_divider_multi;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 24;

    logic                    i_clk = 1'b0;
    logic                    i_reset = 1'b1;
    logic [NUM_CH-1:0]       i_en = '0;
    logic [NUM_CH-1:0]       i_load = '0;
    logic [NUM_CH*CNT_W-1:0] i_half_period = '0;
    logic [NUM_CH-1:0]       o_clk, o_edge, o_busy;
    logic                    o_mix;

    int total = 0;
    int bad   = 0;

    tone_divider_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_en          (i_en),
        .i_load        (i_load),
        .i_half_period (i_half_period),
        .o_clk         (o_clk),
        .o_edge        (o_edge),
        .o_busy        (o_busy),
        .o_mix         (o_mix)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_en = '0; i_load = '0;
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        tick();
    endtask

    // Load a period into an idle channel and start it; returns after the
    // entry edge (sample index 0).
    task automatic start_ch(input int ch, input int half);
        i_half_period[ch*CNT_W +: CNT_W] = CNT_W'(half);
        i_load[ch] = 1'b1;
        tick();
        i_load[ch] = 1'b0;
        i_en[ch] = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        tick(); tick();
        total++; if (o_clk !== 4'b0)  begin bad++; $display("FAIL rst_clk got %b exp 0000", o_clk); end
        total++; if (o_edge !== 4'b0) begin bad++; $display("FAIL rst_edge got %b exp 0000", o_edge); end
        total++; if (o_busy !== 4'b0) begin bad++; $display("FAIL rst_busy got %b exp 0000", o_busy); end
        total++; if (o_mix !== 1'b0)  begin bad++; $display("FAIL rst_mix got %b exp 0", o_mix); end
        i_reset = 1'b0;
        tick();
        total++; if (o_busy !== 4'b0) begin bad++; $display("FAIL idle_busy got %b exp 0000", o_busy); end
    endtask

    // Default period: first rise 56818 cycles after RUN entry, then reset
    // mid-tone must clear every output without a clock edge.
    task automatic test_default_and_reset_mid();
        int first;
        first = -1;
        i_en[0] = 1'b1;
        tick();
        total++; if (o_busy[0] !== 1'b1) begin bad++; $display("FAIL def_busy got %b exp 1", o_busy[0]); end
        for (int n = 1; n <= 60000; n++) begin
            tick();
            if (o_clk[0] === 1'b1) begin first = n; break; end
        end
        total++; if (first != 56818) begin bad++; $display("FAIL def_first_rise got %0d exp 56818", first); end
        total++; if (o_edge[0] !== 1'b1) begin bad++; $display("FAIL def_edge got %b exp 1", o_edge[0]); end
        i_reset = 1'b1;
        #1;
        total++; if (o_clk !== 4'b0)  begin bad++; $display("FAIL mid_rst_clk got %b exp 0000", o_clk); end
        total++; if (o_edge !== 4'b0) begin bad++; $display("FAIL mid_rst_edge got %b exp 0000", o_edge); end
        total++; if (o_busy !== 4'b0) begin bad++; $display("FAIL mid_rst_busy got %b exp 0000", o_busy); end
        total++; if (o_mix !== 1'b0)  begin bad++; $display("FAIL mid_rst_mix got %b exp 0", o_mix); end
        i_en = '0;
        tick();
        i_reset = 1'b0;
        tick();
    endtask

    // Ch1 half-period 5: 5 high / 5 low, one o_edge per rise.
    task automatic test_load_idle();
        logic ec, ee;
        i_half_period[1*CNT_W +: CNT_W] = CNT_W'(5);
        i_load[1] = 1'b1;
        tick();
        i_load[1] = 1'b0;
        total++; if (o_busy[1] !== 1'b0) begin bad++; $display("FAIL load_no_start got %b exp 0", o_busy[1]); end
        i_en[1] = 1'b1;
        tick();
        for (int n = 1; n <= 30; n++) begin
            tick();
            ec = ((n / 5) % 2) == 1;
            ee = (n % 10) == 5;
            total++; if (o_clk[1] !== ec)  begin bad++; $display("FAIL p5_clk n=%0d got %b exp %b", n, o_clk[1], ec); end
            total++; if (o_edge[1] !== ee) begin bad++; $display("FAIL p5_edge n=%0d got %b exp %b", n, o_edge[1], ee); end
        end
        i_en[1] = 1'b0;
        tick();
        total++; if (o_busy[1] !== 1'b0) begin bad++; $display("FAIL p5_stop_busy got %b exp 0", o_busy[1]); end
        total++; if (o_clk[1] !== 1'b0)  begin bad++; $display("FAIL p5_stop_clk got %b exp 0", o_clk[1]); end
    endtask

    // Ch0 P=10, load 3 during the high phase: current high stays 10 long.
    task automatic test_load_mid_high();
        logic ec, ee;
        do_reset();
        start_ch(0, 10);
        for (int n = 1; n <= 32; n++) begin
            tick();
            if (n < 10)      ec = 1'b0;
            else if (n < 20) ec = 1'b1;
            else             ec = (((n - 20) / 3) % 2) == 1;
            ee = (n == 10) || (n == 23) || (n == 29);
            total++; if (o_clk[0] !== ec)  begin bad++; $display("FAIL mid_clk n=%0d got %b exp %b", n, o_clk[0], ec); end
            total++; if (o_edge[0] !== ee) begin bad++; $display("FAIL mid_edge n=%0d got %b exp %b", n, o_edge[0], ee); end
            if (n == 14) begin
                i_half_period[0 +: CNT_W] = CNT_W'(3);
                i_load[0] = 1'b1;
            end
            if (n == 15) i_load[0] = 1'b0;
        end
        i_en[0] = 1'b0;
        tick();
        total++; if (o_busy[0] !== 1'b0) begin bad++; $display("FAIL mid_stop_busy got %b exp 0", o_busy[0]); end
    endtask

    // Ch0 P=4, load 7 on the terminal-count cycle of the high phase.
    task automatic test_load_on_tc();
        logic ec, ee;
        do_reset();
        start_ch(0, 4);
        for (int n = 1; n <= 24; n++) begin
            tick();
            ec = (n >= 4 && n <= 7) || (n >= 15 && n <= 21);
            ee = (n == 4) || (n == 15);
            total++; if (o_clk[0] !== ec)  begin bad++; $display("FAIL tc_clk n=%0d got %b exp %b", n, o_clk[0], ec); end
            total++; if (o_edge[0] !== ee) begin bad++; $display("FAIL tc_edge n=%0d got %b exp %b", n, o_edge[0], ee); end
            if (n == 7) begin
                i_half_period[0 +: CNT_W] = CNT_W'(7);
                i_load[0] = 1'b1;
            end
            if (n == 8) i_load[0] = 1'b0;
        end
        i_en[0] = 1'b0;
        tick();
        total++; if (o_busy[0] !== 1'b0) begin bad++; $display("FAIL tc_stop_busy got %b exp 0", o_busy[0]); end
    endtask

    // Ch2 P=8, en dropped during the cnt=2 cycle of the high phase.
    task automatic test_stop_high();
        logic ec, eb, ee;
        do_reset();
        start_ch(2, 8);
        for (int n = 1; n <= 20; n++) begin
            tick();
            ec = (n >= 8) && (n <= 15);
            eb = (n <= 15);
            ee = (n == 8);
            total++; if (o_clk[2] !== ec)  begin bad++; $display("FAIL stop_clk n=%0d got %b exp %b", n, o_clk[2], ec); end
            total++; if (o_busy[2] !== eb) begin bad++; $display("FAIL stop_busy n=%0d got %b exp %b", n, o_busy[2], eb); end
            total++; if (o_edge[2] !== ee) begin bad++; $display("FAIL stop_edge n=%0d got %b exp %b", n, o_edge[2], ee); end
            if (n == 10) i_en[2] = 1'b0;
        end
    endtask

    // Ch0 P=2 and ch1 P=3 together; o_mix trails their OR by one cycle.
    task automatic test_mix();
        logic c0, c1, em;
        do_reset();
        i_half_period[0*CNT_W +: CNT_W] = CNT_W'(2);
        i_half_period[1*CNT_W +: CNT_W] = CNT_W'(3);
        i_load[1:0] = 2'b11;
        tick();
        i_load[1:0] = 2'b00;
        i_en[1:0] = 2'b11;
        tick();
        for (int n = 1; n <= 20; n++) begin
            tick();
            c0 = ((n / 2) % 2) == 1;
            c1 = ((n / 3) % 2) == 1;
`ifdef TONE_DIVIDER_MIX_EN
            em = (((n - 1) / 2) % 2 == 1) || (((n - 1) / 3) % 2 == 1);
`else
            em = 1'b0;
`endif
            total++; if (o_clk[0] !== c0) begin bad++; $display("FAIL mix_c0 n=%0d got %b exp %b", n, o_clk[0], c0); end
            total++; if (o_clk[1] !== c1) begin bad++; $display("FAIL mix_c1 n=%0d got %b exp %b", n, o_clk[1], c1); end
            total++; if (o_mix !== em)    begin bad++; $display("FAIL mix_out n=%0d got %b exp %b", n, o_mix, em); end
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_default_and_reset_mid();
        test_load_idle();
        test_load_mid_high();
        test_load_on_tc();
        test_stop_high();
        test_mix();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
